bist_sequencer: RTL and testbench

//  Parametrised successor of the single-seed/single-polynomial BIST controller.

---
 rtl/bist_sequencer.sv | 173 +++++++++++++++++
 tb/tb_bist_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: sweeps every (polynomial, seed) pair through the LFSR/MISR
// test path. It applies PATTERNS vectors per pair and then compares the
// accumulated MISR signature against GOLDEN_SIG.
// Optional feature: define BIST_ABORT_EN to add the `abort` input, which ends
// a run early (INIT or RUN only) with pass=0.
// All outputs are registered; they are decoded from the next state.
module bist_sequencer #(
    parameter int                 N_POLYS    = 2,
    parameter int                 N_SEEDS    = 4,
    parameter int                 PATTERNS   = 32,
    parameter int                 SIG_W      = 16,
    parameter logic [SIG_W-1:0]   GOLDEN_SIG = {SIG_W{1'b0}},
    localparam int                PS_W = (N_POLYS  > 1) ? $clog2(N_POLYS)  : 1,
    localparam int                SS_W = (N_SEEDS  > 1) ? $clog2(N_SEEDS)  : 1,
    localparam int                PC_W = (PATTERNS > 1) ? $clog2(PATTERNS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [SIG_W-1:0] misr_sig,
    output logic             bist_out,
    output logic             init,
    output logic             misr_en,
    output logic [PS_W-1:0]  poly_sel,
    output logic [SS_W-1:0]  seed_sel,
    output logic             bist_end,
    output logic             finish,
    output logic             pass
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [PS_W-1:0] POLY_LAST = PS_W'(N_POLYS - 1);
    localparam logic [SS_W-1:0] SEED_LAST = SS_W'(N_SEEDS - 1);
    localparam logic [PC_W-1:0] PAT_LAST  = PC_W'(PATTERNS - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_start_q;
    logic [PC_W-1:0] r_pat_cnt;
    logic [PS_W-1:0] r_poly;
    logic [SS_W-1:0] r_seed;
    logic            r_bist_out;
    logic            r_init;
    logic            r_misr_en;
    logic            r_bist_end;
    logic            r_finish;
    logic            r_pass;

    logic w_start_rise;
    logic w_abort;
    logic w_last_pat;
    logic w_last_seed;
    logic w_last_poly;
    logic w_next_session;
    logic w_restart;

    assign w_start_rise = start & ~r_start_q;
`ifdef BIST_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif
    assign w_last_pat  = (r_pat_cnt == PAT_LAST);
    assign w_last_seed = (r_seed == SEED_LAST);
    assign w_last_poly = (r_poly == POLY_LAST);

    // Moving from one session to the next advances the (poly, seed) indices
    assign w_next_session = (r_state == S_RUN) && (w_next_state == S_INIT);
    // A restart from DONE begins a fresh sweep from (0,0)
    assign w_restart      = (r_state == S_DONE) && (w_next_state == S_INIT);

    // Next-state logic: start edges matter only in IDLE and DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) w_next_state = S_INIT;
                else              w_next_state = S_IDLE;
            end
            S_INIT: begin
                if (w_abort) w_next_state = S_DONE;
                else         w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_abort)                        w_next_state = S_DONE;
                else if (!w_last_pat)               w_next_state = S_RUN;
                else if (w_last_seed && w_last_poly) w_next_state = S_COMPARE;
                else                                w_next_state = S_INIT;
            end
            S_COMPARE: w_next_state = S_DONE;
            S_DONE: begin
                if (w_start_rise) w_next_state = S_INIT;
                else              w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, counters, indices and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_pat_cnt  <= {PC_W{1'b0}};
            r_poly     <= {PS_W{1'b0}};
            r_seed     <= {SS_W{1'b0}};
            r_bist_out <= 1'b0;
            r_init     <= 1'b0;
            r_misr_en  <= 1'b0;
            r_bist_end <= 1'b0;
            r_finish   <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_q <= start;

            if ((r_state == S_RUN) && (w_next_state == S_RUN)) begin
                r_pat_cnt <= r_pat_cnt + PC_W'(1);
            end else begin
                r_pat_cnt <= {PC_W{1'b0}};
            end

            if (w_restart) begin
                r_poly <= {PS_W{1'b0}};
                r_seed <= {SS_W{1'b0}};
            end else if (w_next_session && !w_last_seed) begin
                r_seed <= r_seed + SS_W'(1);
            end else if (w_next_session) begin
                r_seed <= {SS_W{1'b0}};
                r_poly <= r_poly + PS_W'(1);
            end else begin
                r_poly <= r_poly;
                r_seed <= r_seed;
            end

            r_init     <= (w_next_state == S_INIT);
            r_bist_out <= (w_next_state == S_INIT) || (w_next_state == S_RUN);
            r_misr_en  <= (w_next_state == S_RUN);
            r_bist_end <= (w_next_state == S_DONE);
            r_finish   <= (w_next_state == S_DONE) && (r_state != S_DONE);

            // pass is captured in COMPARE; an abort entry to DONE forces it low
            if (r_state == S_COMPARE) begin
                r_pass <= (misr_sig == GOLDEN_SIG);
            end else if ((w_next_state == S_INIT) ||
                         ((w_next_state == S_DONE) && (r_state != S_DONE))) begin
                r_pass <= 1'b0;
            end else begin
                r_pass <= r_pass;
            end
        end
    end

    assign bist_out = r_bist_out;
    assign init     = r_init;
    assign misr_en  = r_misr_en;
    assign poly_sel = r_poly;
    assign seed_sel = r_seed;
    assign bist_end = r_bist_end;
    assign finish   = r_finish;
    assign pass     = r_pass;

endmodule

// File: tb/tb_bist_sequencer.sv
// Testbench for bist_sequencer. A directed normal run is followed by random
// start, rst, misr_sig and abort stimulus. Every output is compared each cycle
// with a reference model that tracks the run as a cycle offset from the first
// init. The model derives session, phase and indices from that offset.
module tb_bist_sequencer;

    localparam int NP    = 2;
    localparam int NS    = 2;
    localparam int PAT   = 4;
    localparam logic [15:0] GOLD = 16'hA5C3;
    localparam int TOTAL = NP * NS * (PAT + 1);
    localparam int PS_W  = (NP  > 1) ? $clog2(NP)  : 1;
    localparam int SS_W  = (NS  > 1) ? $clog2(NS)  : 1;
    localparam int N_CYC = 3000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort_s;
    logic [15:0]     misr_sig;
    logic            bist_out, init, misr_en, bist_end, finish, pass;
    logic [PS_W-1:0] poly_sel;
    logic [SS_W-1:0] seed_sel;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    int m_mode = 0;   // 0 idle, 1 running (t indexes init/run cycles, t==TOTAL is compare), 2 done
    int m_t    = 0;
    int m_poly = 0;
    int m_seed = 0;
    bit m_prev = 1'b0;
    bit m_pass = 1'b0;
    bit m_fin  = 1'b0;

    always #5 clk = ~clk;

    bist_sequencer #(
        .N_POLYS   (NP),
        .N_SEEDS   (NS),
        .PATTERNS  (PAT),
        .SIG_W     (16),
        .GOLDEN_SIG(GOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef BIST_ABORT_EN
        .abort    (abort_s),
`endif
        .misr_sig (misr_sig),
        .bist_out (bist_out),
        .init     (init),
        .misr_en  (misr_en),
        .poly_sel (poly_sel),
        .seed_sel (seed_sel),
        .bist_end (bist_end),
        .finish   (finish),
        .pass     (pass)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // One rising clock edge of the reference model with the inputs present at that edge
    task automatic model_step(input bit r, input bit s, input logic [15:0] sig, input bit ab);
        bit rise;
        if (r) begin
            m_mode = 0; m_t = 0; m_prev = 1'b0; m_pass = 1'b0; m_fin = 1'b0;
            m_poly = 0; m_seed = 0;
        end else begin
            rise   = s && !m_prev;
            m_prev = s;
            m_fin  = 1'b0;
            case (m_mode)
                0: if (rise) begin m_mode = 1; m_t = 0; end
                1: begin
                    if (ab && m_t < TOTAL) begin
                        m_mode = 2; m_pass = 1'b0; m_fin = 1'b1;
                    end else if (m_t == TOTAL) begin
                        m_mode = 2; m_pass = (sig == GOLD); m_fin = 1'b1;
                    end else begin
                        m_t++;
                    end
                end
                default: if (rise) begin m_mode = 1; m_t = 0; m_pass = 1'b0; end
            endcase
            if (m_mode == 1 && m_t < TOTAL) begin
                m_poly = (m_t / (PAT + 1)) / NS;
                m_seed = (m_t / (PAT + 1)) % NS;
            end
        end
    endtask

    task automatic check_all();
        bit act;
        act = (m_mode == 1) && (m_t < TOTAL);
        check_val("init",     {15'd0, init},     {15'd0, act && (m_t % (PAT + 1) == 0)});
        check_val("misr_en",  {15'd0, misr_en},  {15'd0, act && (m_t % (PAT + 1) != 0)});
        check_val("bist_out", {15'd0, bist_out}, {15'd0, act});
        check_val("bist_end", {15'd0, bist_end}, {15'd0, m_mode == 2});
        check_val("finish",   {15'd0, finish},   {15'd0, m_fin});
        check_val("pass",     {15'd0, pass},     {15'd0, m_pass});
        check_val("poly_sel", 16'(poly_sel),     16'(m_poly));
        check_val("seed_sel", 16'(seed_sel),     16'(m_seed));
    endtask

    // Picks the inputs for the next clock edge: directed prologue, then random
    task automatic drive_inputs();
        if (cyc < 2) begin
            rst = 1'b1; start = 1'b0; misr_sig = GOLD; abort_s = 1'b0;
        end else if (cyc < 40) begin
            rst = 1'b0; start = (cyc == 4); misr_sig = GOLD; abort_s = 1'b0;
        end else if (cyc < 110) begin
            // start held for 30 cycles with extra pulses afterwards, then a wrong signature
            rst = 1'b0; abort_s = 1'b0;
            start = (cyc >= 42 && cyc < 72) || cyc == 75 || cyc == 80;
            misr_sig = 16'h0000;
        end else begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) start = ~start;
            misr_sig = ($urandom_range(0, 1) == 1) ? GOLD : 16'($urandom);
`ifdef BIST_ABORT_EN
            abort_s = ($urandom_range(0, 39) == 0);
`else
            abort_s = 1'b0;
`endif
        end
`ifdef BIST_ABORT_EN
        model_step(rst, start, misr_sig, abort_s);
`else
        model_step(rst, start, misr_sig, 1'b0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; misr_sig = GOLD; abort_s = 1'b0;
        drive_inputs();
        for (int i = 0; i < N_CYC; i++) begin
            @(negedge clk);
            check_all();
            cyc++;
            drive_inputs();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
